// File: rtl/fd_flash_reader_if.sv
// Exposure-lookup handshake between the metering FSM (master) and the flash reader (slave).
interface fd_flash_reader_if;
   logic [23:0] fd_address;
   logic        fd_valid;
   logic [7:0]  fd;
   logic        fd_ready;
   logic        fd_busy;

   modport master (output fd_address, output fd_valid,
                   input  fd, input fd_ready, input fd_busy);
   modport slave  (input  fd_address, input fd_valid,
                   output fd, output fd_ready, output fd_busy);
endinterface

// File: rtl/fd_flash_reader.sv
// Reads one byte from SPI NOR flash (0x03 READ, mode 0) per exposure lookup.
// Optional single-entry lookup cache: define FD_FLASH_CACHE_EN.
module fd_flash_reader #(
   parameter int         CLK_DIV  = 2,
   parameter logic [7:0] READ_CMD = 8'h03
) (
   input  logic               clk,
   input  logic               rst,
   fd_flash_reader_if.slave   fdb,
   output logic               spi_cs_n,
   output logic               spi_sck,
   output logic               spi_mosi,
   input  logic               spi_miso
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CS_SETUP = 3'd1,
      SHIFT    = 3'd2,
      CS_HOLD  = 3'd3,
      DONE     = 3'd4
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t      state, state_n;
   logic [7:0]  cnt, cnt_n;
   logic [5:0]  bit_cnt, bit_cnt_n;
   logic [31:0] sr, sr_n;
   logic [7:0]  rx, rx_n;
   logic [7:0]  fd_q, fd_n;
   logic        rdy_q, rdy_n;
   logic        busy_q, busy_n;
   logic        cs_n_n, sck_n, mosi_n;
   logic        phase_end;

   assign phase_end    = (cnt == DIV_LAST);
   assign fdb.fd       = fd_q;
   assign fdb.fd_ready = rdy_q;
   assign fdb.fd_busy  = busy_q;

`ifdef FD_FLASH_CACHE_EN
   logic        cache_vld;
   logic [23:0] cache_addr;
   logic [23:0] addr_q;
   logic [7:0]  cache_data;
   logic        hit;

   assign hit = cache_vld && (fdb.fd_address == cache_addr);
`endif

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_cnt_n = bit_cnt;
      sr_n      = sr;
      rx_n      = rx;
      fd_n      = fd_q;
      rdy_n     = 1'b0;
      busy_n    = busy_q;
      cs_n_n    = spi_cs_n;
      sck_n     = spi_sck;
      mosi_n    = spi_mosi;
      case (state)
         IDLE: begin
            if (fdb.fd_valid) begin
               busy_n = 1'b1;
`ifdef FD_FLASH_CACHE_EN
               if (hit) begin
                  state_n = DONE;
                  fd_n    = cache_data;
                  rdy_n   = 1'b1;
               end else
`endif
               begin
                  state_n   = CS_SETUP;
                  cs_n_n    = 1'b0;
                  cnt_n     = 8'd0;
                  bit_cnt_n = 6'd0;
                  sr_n      = {READ_CMD, fdb.fd_address};
               end
            end
         end
         CS_SETUP: begin
            if (phase_end) begin
               state_n = SHIFT;
               cnt_n   = 8'd0;
               mosi_n  = sr[31];
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         SHIFT: begin
            if (!phase_end) begin
               cnt_n = cnt + 8'd1;
            end else begin
               cnt_n = 8'd0;
               if (!spi_sck) begin
                  sck_n = 1'b1;
                  rx_n  = {rx[6:0], spi_miso};
               end else begin
                  sck_n = 1'b0;
                  if (bit_cnt == 6'd39) begin
                     state_n = CS_HOLD;
                     mosi_n  = 1'b0;
                  end else begin
                     // Zeros shift in behind the frame, so MOSI idles low for the read bits.
                     bit_cnt_n = bit_cnt + 6'd1;
                     sr_n      = {sr[30:0], 1'b0};
                     mosi_n    = sr[30];
                  end
               end
            end
         end
         CS_HOLD: begin
            if (phase_end) begin
               state_n = DONE;
               cs_n_n  = 1'b1;
               fd_n    = rx;
               rdy_n   = 1'b1;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         DONE: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
         default: begin
            state_n = IDLE;
            cs_n_n  = 1'b1;
            sck_n   = 1'b0;
            mosi_n  = 1'b0;
            fd_n    = 8'h00;
            busy_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 8'd0;
         bit_cnt  <= 6'd0;
         fd_q     <= 8'h00;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
         spi_cs_n <= 1'b1;
         spi_sck  <= 1'b0;
         spi_mosi <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         bit_cnt  <= bit_cnt_n;
         fd_q     <= fd_n;
         rdy_q    <= rdy_n;
         busy_q   <= busy_n;
         spi_cs_n <= cs_n_n;
         spi_sck  <= sck_n;
         spi_mosi <= mosi_n;
      end
   end

`ifdef FD_FLASH_CACHE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cache_vld <= 1'b0;
      end else if (state == CS_HOLD && phase_end) begin
         cache_vld <= 1'b1;
      end
   end
`endif

   // Datapath registers carry no reset; they are always reloaded before use.
   always_ff @(posedge clk) begin
      sr <= sr_n;
      rx <= rx_n;
`ifdef FD_FLASH_CACHE_EN
      if (state == IDLE && fdb.fd_valid) begin
         addr_q <= fdb.fd_address;
      end
      if (state == CS_HOLD && phase_end) begin
         cache_addr <= addr_q;
         cache_data <= rx;
      end
`endif
   end

endmodule
